// File: rtl/combat_pkg.sv
// combat_pkg
// Purpose : Encodings and geometry helper shared by combat_resolver and
//           fighter_state.
// Contents: round_state_t (FIGHT/KO/ROUND_OVER), winner_t (NONE/P1/P2/DRAW),
//           FACE_RIGHT/FACE_LEFT, in_reach() attack geometry test.
package combat_pkg;

  typedef enum logic [1:0] {
    ST_FIGHT      = 2'd0,
    ST_KO         = 2'd1,
    ST_ROUND_OVER = 2'd2
  } round_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

  localparam logic FACE_RIGHT = 1'b0;
  localparam logic FACE_LEFT  = 1'b1;

  // Widened to 11 bits so x + span cannot wrap at the right screen edge.
  function automatic logic in_reach(input logic [9:0]  att_x,
                                    input logic [9:0]  att_y,
                                    input logic        att_facing,
                                    input logic [9:0]  def_x,
                                    input logic [9:0]  def_y,
                                    input logic [10:0] span);
    logic [10:0] ax;
    logic [10:0] dx;
    logic        hit;
    ax  = {1'b0, att_x};
    dx  = {1'b0, def_x};
    hit = 1'b0;
    if (att_y == def_y) begin
      case (att_facing)
        FACE_RIGHT: hit = (dx > ax) && (dx < ax + span);
        FACE_LEFT:  hit = (dx < ax) && (ax < dx + span);
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/combat_resolver_fighter_state.sv
// fighter_state
// Purpose : Per-fighter health, shield energy, hit cooldown, shield regen
//           timer and (optionally) attacker combo tracking.
// Optional: COMBAT_COMBO_EN enables the combo counter / window timer.
// Ports   :
//   i_clk, i_reset        clock, async active-high reset
//   i_take_hit            this fighter takes an unblocked hit this cycle
//   i_take_block          this fighter blocks a hit this cycle
//   i_dmg_amount          health removed by i_take_hit
//   i_shield_btn          shield button level
//   i_restore             round restart: reload health/shield, clear timers
//   i_land_hit            this fighter landed a damaging hit (combo)
//   i_land_block          this fighter's hit was blocked (combo)
//   o_health, o_health_nxt  current / next-cycle health
//   o_shield, o_shield_active, o_immune
//   o_hit, o_block        one-cycle pulses
//   o_combo               combo depth (0 when combos disabled)
module fighter_state
  import combat_pkg::*;
#(
  parameter int HEALTH_W     = 4,
  parameter int MAX_HEALTH   = 15,
  parameter int SHIELD_W     = 4,
  parameter int MAX_SHIELD   = 15,
  parameter int BLOCK_COST   = 2,
  parameter int COOLDOWN_CYC = 25_000_000,
  parameter int REGEN_CYC    = 50_000_000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_take_hit,
  input  logic                i_take_block,
  input  logic [HEALTH_W-1:0] i_dmg_amount,
  input  logic                i_shield_btn,
  input  logic                i_restore,
  input  logic                i_land_hit,
  input  logic                i_land_block,
  output logic [HEALTH_W-1:0] o_health,
  output logic [HEALTH_W-1:0] o_health_nxt,
  output logic [SHIELD_W-1:0] o_shield,
  output logic                o_shield_active,
  output logic                o_immune,
  output logic                o_hit,
  output logic                o_block,
  output logic [2:0]          o_combo
);

  localparam int CD_W = $clog2(COOLDOWN_CYC + 1);
  localparam int RG_W = $clog2(REGEN_CYC + 1);

  logic [HEALTH_W-1:0] r_health, w_health_nxt;
  logic [SHIELD_W-1:0] r_shield, w_shield_nxt;
  logic [CD_W-1:0]     r_cd, w_cd_nxt;
  logic [RG_W-1:0]     r_rg, w_rg_nxt;
  logic                w_regen;
  logic                r_hit, r_block;

  always_comb begin
    w_health_nxt = r_health;
    w_shield_nxt = r_shield;
    w_cd_nxt     = r_cd;
    w_rg_nxt     = r_rg;
    w_regen      = 1'b0;
    if (i_restore) begin
      w_health_nxt = HEALTH_W'(MAX_HEALTH);
      w_shield_nxt = SHIELD_W'(MAX_SHIELD);
      w_cd_nxt     = '0;
      w_rg_nxt     = '0;
    end else begin
      if (i_take_hit) begin
        w_health_nxt = (r_health > i_dmg_amount) ? r_health - i_dmg_amount : '0;
        w_cd_nxt     = CD_W'(COOLDOWN_CYC);
      end else if (r_cd != '0) begin
        w_cd_nxt = r_cd - CD_W'(1);
      end
      // Timer only runs while regen is actually possible; a full shield parks it at 0.
      if (i_shield_btn || (r_shield >= SHIELD_W'(MAX_SHIELD))) begin
        w_rg_nxt = '0;
      end else if (r_rg == RG_W'(REGEN_CYC - 1)) begin
        w_rg_nxt = '0;
        w_regen  = 1'b1;
      end else begin
        w_rg_nxt = r_rg + RG_W'(1);
      end
      if (i_take_block) begin
        w_shield_nxt = (r_shield > SHIELD_W'(BLOCK_COST)) ?
                       r_shield - SHIELD_W'(BLOCK_COST) : '0;
      end else if (w_regen) begin
        w_shield_nxt = r_shield + SHIELD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_health <= HEALTH_W'(MAX_HEALTH);
      r_shield <= SHIELD_W'(MAX_SHIELD);
      r_cd     <= '0;
      r_rg     <= '0;
      r_hit    <= 1'b0;
      r_block  <= 1'b0;
    end else begin
      r_health <= w_health_nxt;
      r_shield <= w_shield_nxt;
      r_cd     <= w_cd_nxt;
      r_rg     <= w_rg_nxt;
      r_hit    <= i_take_hit;
      r_block  <= i_take_block;
    end
  end

  assign o_health        = r_health;
  assign o_health_nxt    = w_health_nxt;
  assign o_shield        = r_shield;
  assign o_shield_active = i_shield_btn && (r_shield != '0);
  assign o_immune        = (r_cd != '0);
  assign o_hit           = r_hit;
  assign o_block         = r_block;

`ifdef COMBAT_COMBO_EN
  localparam int         WINDOW    = COOLDOWN_CYC + COOLDOWN_CYC / 2;
  localparam int         WN_W      = $clog2(WINDOW + 1);
  localparam logic [2:0] COMBO_MAX = 3'd7;

  logic [2:0]      r_combo;
  logic [WN_W-1:0] r_win;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_combo <= '0;
      r_win   <= '0;
    end else if (i_restore || i_land_block) begin
      r_combo <= '0;
      r_win   <= '0;
    end else if (i_land_hit) begin
      if (r_win != '0)
        r_combo <= (r_combo == COMBO_MAX) ? r_combo : r_combo + 3'd1;
      else
        r_combo <= 3'd1;
      r_win <= WN_W'(WINDOW);
    end else if (r_win != '0) begin
      r_win <= r_win - WN_W'(1);
      if (r_win == WN_W'(1))
        r_combo <= '0;
    end
  end

  assign o_combo = r_combo;
`else
  logic w_unused_land;
  assign w_unused_land = i_land_hit | i_land_block;
  assign o_combo       = '0;
`endif

endmodule

// File: rtl/combat_resolver.sv
// combat_resolver
// Purpose : Two-fighter hit/shield/round resolver. Detects attack edges,
//           tests reach geometry, routes hits/blocks to two fighter_state
//           instances and runs the round FSM (FIGHT -> KO -> ROUND_OVER).
// Optional: COMBAT_COMBO_EN enables combos (double damage at combo >= 3).
// Ports   :
//   i_clk, i_reset                 clock, async active-high reset
//   i_p1_x/y, i_p2_x/y             fighter left/top pixel
//   i_p1_facing, i_p2_facing       0 = right, 1 = left
//   i_p1_attack_req, i_p2_attack_req   level attack requests
//   i_p1_shield_btn, i_p2_shield_btn   level shield requests
//   i_round_start                  pulse, starts next round from ROUND_OVER
//   o_p1/p2_health, o_p1/p2_shield, o_p1/p2_shield_active
//   o_p1/p2_hit, o_p1/p2_block     one-cycle pulses
//   o_round_state, o_winner, o_combo_count
module combat_resolver
  import combat_pkg::*;
#(
  parameter int HEALTH_W     = 4,
  parameter int MAX_HEALTH   = 15,
  parameter int SHIELD_W     = 4,
  parameter int MAX_SHIELD   = 15,
  parameter int DAMAGE       = 1,
  parameter int BLOCK_COST   = 2,
  parameter int HITBOX_W     = 70,
  parameter int REACH        = 20,
  parameter int COOLDOWN_CYC = 25_000_000,
  parameter int REGEN_CYC    = 50_000_000,
  parameter int KO_HOLD_CYC  = 100_000_000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [9:0]          i_p1_x,
  input  logic [9:0]          i_p2_x,
  input  logic [9:0]          i_p1_y,
  input  logic [9:0]          i_p2_y,
  input  logic                i_p1_facing,
  input  logic                i_p2_facing,
  input  logic                i_p1_attack_req,
  input  logic                i_p2_attack_req,
  input  logic                i_p1_shield_btn,
  input  logic                i_p2_shield_btn,
  input  logic                i_round_start,
  output logic [HEALTH_W-1:0] o_p1_health,
  output logic [HEALTH_W-1:0] o_p2_health,
  output logic [SHIELD_W-1:0] o_p1_shield,
  output logic [SHIELD_W-1:0] o_p2_shield,
  output logic                o_p1_shield_active,
  output logic                o_p2_shield_active,
  output logic                o_p1_hit,
  output logic                o_p2_hit,
  output logic                o_p1_block,
  output logic                o_p2_block,
  output logic [1:0]          o_round_state,
  output logic [1:0]          o_winner,
  output logic [2:0]          o_combo_count
);

  localparam logic [10:0] SPAN = 11'(HITBOX_W + REACH);
  localparam int          KO_W = $clog2(KO_HOLD_CYC + 1);

  round_state_t        r_state, w_state_nxt;
  winner_t             r_winner, w_winner_nxt;
  logic [KO_W-1:0]     r_ko, w_ko_nxt;
  logic                w_restore;

  logic                r_p1_atk_d, r_p2_atk_d;
  logic                w_p1_strike, w_p2_strike;
  logic                w_p1_reach, w_p2_reach;
  logic                w_p1_lands, w_p2_lands;
  logic                w_fight;
  logic                w_p1_take_hit, w_p1_take_block, w_p2_take_hit, w_p2_take_block;
  logic                w_p1_immune, w_p2_immune;
  logic [HEALTH_W-1:0] w_p1_health_nxt, w_p2_health_nxt;
  logic [HEALTH_W-1:0] w_p1_dmg, w_p2_dmg;
  logic [2:0]          w_p1_combo, w_p2_combo;
  logic                w_p1_zero, w_p2_zero;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p1_atk_d <= 1'b0;
      r_p2_atk_d <= 1'b0;
    end else begin
      r_p1_atk_d <= i_p1_attack_req;
      r_p2_atk_d <= i_p2_attack_req;
    end
  end

  assign w_p1_strike = i_p1_attack_req & ~r_p1_atk_d;
  assign w_p2_strike = i_p2_attack_req & ~r_p2_atk_d;
  assign w_p1_reach  = in_reach(i_p1_x, i_p1_y, i_p1_facing, i_p2_x, i_p2_y, SPAN);
  assign w_p2_reach  = in_reach(i_p2_x, i_p2_y, i_p2_facing, i_p1_x, i_p1_y, SPAN);
  assign w_fight     = (r_state == ST_FIGHT);

  // w_pN_lands: pN's strike connects with the opponent (hit or block).
  assign w_p1_lands = w_p1_strike & w_p1_reach & ~w_p2_immune & w_fight;
  assign w_p2_lands = w_p2_strike & w_p2_reach & ~w_p1_immune & w_fight;

  assign w_p2_take_block = w_p1_lands &  o_p2_shield_active;
  assign w_p2_take_hit   = w_p1_lands & ~o_p2_shield_active;
  assign w_p1_take_block = w_p2_lands &  o_p1_shield_active;
  assign w_p1_take_hit   = w_p2_lands & ~o_p1_shield_active;

`ifdef COMBAT_COMBO_EN
  // Damage taken is set by the attacker's combo depth before this hit.
  assign w_p2_dmg      = (w_p1_combo >= 3'd3) ? HEALTH_W'(2 * DAMAGE) : HEALTH_W'(DAMAGE);
  assign w_p1_dmg      = (w_p2_combo >= 3'd3) ? HEALTH_W'(2 * DAMAGE) : HEALTH_W'(DAMAGE);
  assign o_combo_count = (w_p1_combo > w_p2_combo) ? w_p1_combo : w_p2_combo;
`else
  logic w_unused_combo;
  assign w_unused_combo = ^{w_p1_combo, w_p2_combo};
  assign w_p2_dmg       = HEALTH_W'(DAMAGE);
  assign w_p1_dmg       = HEALTH_W'(DAMAGE);
  assign o_combo_count  = 3'd0;
`endif

  fighter_state #(
    .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .SHIELD_W(SHIELD_W),
    .MAX_SHIELD(MAX_SHIELD), .BLOCK_COST(BLOCK_COST),
    .COOLDOWN_CYC(COOLDOWN_CYC), .REGEN_CYC(REGEN_CYC)
  ) u_p1 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_take_hit(w_p1_take_hit), .i_take_block(w_p1_take_block),
    .i_dmg_amount(w_p1_dmg), .i_shield_btn(i_p1_shield_btn),
    .i_restore(w_restore),
    .i_land_hit(w_p2_take_hit), .i_land_block(w_p2_take_block),
    .o_health(o_p1_health), .o_health_nxt(w_p1_health_nxt),
    .o_shield(o_p1_shield), .o_shield_active(o_p1_shield_active),
    .o_immune(w_p1_immune), .o_hit(o_p1_hit), .o_block(o_p1_block),
    .o_combo(w_p1_combo)
  );

  fighter_state #(
    .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .SHIELD_W(SHIELD_W),
    .MAX_SHIELD(MAX_SHIELD), .BLOCK_COST(BLOCK_COST),
    .COOLDOWN_CYC(COOLDOWN_CYC), .REGEN_CYC(REGEN_CYC)
  ) u_p2 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_take_hit(w_p2_take_hit), .i_take_block(w_p2_take_block),
    .i_dmg_amount(w_p2_dmg), .i_shield_btn(i_p2_shield_btn),
    .i_restore(w_restore),
    .i_land_hit(w_p1_take_hit), .i_land_block(w_p1_take_block),
    .o_health(o_p2_health), .o_health_nxt(w_p2_health_nxt),
    .o_shield(o_p2_shield), .o_shield_active(o_p2_shield_active),
    .o_immune(w_p2_immune), .o_hit(o_p2_hit), .o_block(o_p2_block),
    .o_combo(w_p2_combo)
  );

  // KO is decided from post-update health so it appears with the fatal hit.
  assign w_p1_zero = (w_p1_health_nxt == '0);
  assign w_p2_zero = (w_p2_health_nxt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_FIGHT;
      r_winner <= WIN_NONE;
      r_ko     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_winner <= w_winner_nxt;
      r_ko     <= w_ko_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_ko_nxt     = r_ko;
    w_restore    = 1'b0;
    case (r_state)
      ST_FIGHT: begin
        if (w_p1_zero || w_p2_zero) begin
          w_state_nxt = ST_KO;
          w_ko_nxt    = '0;
          if (w_p1_zero && w_p2_zero) w_winner_nxt = WIN_DRAW;
          else if (w_p1_zero)         w_winner_nxt = WIN_P2;
          else                        w_winner_nxt = WIN_P1;
        end
      end
      ST_KO: begin
        if (r_ko == KO_W'(KO_HOLD_CYC - 1)) begin
          w_state_nxt = ST_ROUND_OVER;
          w_ko_nxt    = '0;
        end else begin
          w_ko_nxt = r_ko + KO_W'(1);
        end
      end
      ST_ROUND_OVER: begin
        if (i_round_start) begin
          w_state_nxt  = ST_FIGHT;
          w_winner_nxt = WIN_NONE;
          w_restore    = 1'b1;
        end
      end
      default: w_state_nxt = ST_FIGHT;
    endcase
  end

  assign o_round_state = r_state;
  assign o_winner      = r_winner;

endmodule
